// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central stall/flush controller for the 5-stage pipeline.
//   - Merges stage stall requests into a 6-bit hold vector
//     (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB).
//   - Sequences exception/ERET redirects as a one-cycle freeze followed by a
//     one-cycle flush that carries the redirect PC.
//   - Raises a sticky timeout flag after TIMEOUT_CYCLES consecutive stalled cycles.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   stallreq_if/id/ex/mem  per-stage stall requests
//   exc_valid          exception/ERET committed at MEM this cycle
//   exc_is_eret        qualifies exc_valid: 1 = ERET, 0 = exception
//   cp0_epc            ERET target
//   stall              per-stage hold vector (combinational)
//   flush              clear pipeline registers, load PC from new_pc (registered)
//   new_pc             redirect target, meaningful only while flush=1 (registered)
//   timeout            sticky livelock flag (registered)
//   dbg_state_o        current FSM state (0 = RUN, 1 = FLUSH) for observation
//
// Signalling: there are no valid/ready handshakes here. exc_valid is a
// single-cycle level qualifier sampled only in RUN; flush is a one-cycle pulse
// and consumers must qualify new_pc with flush.

module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0040,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_valid,
    input  logic        exc_is_eret,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        timeout,
    output logic [0:0]  dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       stall_c;

    // Stall vector: a stalled stage holds itself and every earlier stage; the
    // next stage stays free so it picks up a bubble.
    always_comb begin
        stall_c = 6'b000000;
        if (rst) begin
            stall_c = 6'b000000;
        end else if (state_q == ST_FLUSH) begin
            stall_c = 6'b000000;
        end else if (exc_valid) begin
            // Freeze everything so nothing commits in the excepting cycle.
            stall_c = 6'b111111;
        end else if (stallreq_mem) begin
            stall_c = 6'b011111;
        end else if (stallreq_ex) begin
            stall_c = 6'b001111;
        end else if (stallreq_id) begin
            stall_c = 6'b000111;
        end else if (stallreq_if) begin
            stall_c = 6'b000011;
        end
    end

    // Next-state logic. The FLUSH state lasts exactly one cycle and ignores
    // all inputs, so a new exception can only be accepted from the cycle after.
    always_comb begin
        state_d   = ST_RUN;
        new_pc_d  = new_pc_q;
        timeout_d = timeout_q;
        cnt_d     = '0;

        if (state_q == ST_RUN && exc_valid) begin
            state_d  = ST_FLUSH;
            new_pc_d = exc_is_eret ? cp0_epc : EXC_VECTOR;
        end

        // Count only genuine stalls in RUN; the freeze cycle, FLUSH and any
        // unstalled cycle restart the count. Saturates, never wraps.
        if (state_q == ST_RUN && !exc_valid && stall_c != 6'b000000) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end

        // The flag rises on the edge where the count reaches the limit.
        if (cnt_d == CNT_MAX) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            new_pc_q  <= 32'h0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            new_pc_q  <= new_pc_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign stall       = stall_c;
    assign flush       = (state_q == ST_FLUSH);
    assign new_pc      = new_pc_q;
    assign timeout     = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        exc_valid;
  logic        exc_is_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout;
  logic [0:0]  dbg_state;

  int n_checks;
  int n_errors;

  pipeline_ctrl #(
    .EXC_VECTOR    (32'h0000_0040),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_if (stallreq_if),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .exc_valid   (exc_valid),
    .exc_is_eret (exc_is_eret),
    .cp0_epc     (cp0_epc),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .timeout     (timeout),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic i_f, input logic i_d, input logic e_x, input logic m_m);
    stallreq_if  = i_f;
    stallreq_id  = i_d;
    stallreq_ex  = e_x;
    stallreq_mem = m_m;
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    exc_valid    = 1'b0;
    exc_is_eret  = 1'b0;
    cp0_epc      = 32'h0;
    set_req(1, 1, 1, 1);

    // 1 reset with all requests high
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_stall", {26'h0, stall}, 32'h0);
    end
    check("rst_flush", {31'h0, flush}, 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    check("rst_timeout", {31'h0, timeout}, 32'h0);
    check("rst_state", {31'h0, dbg_state}, 32'h0);

    rst = 1'b0;
    set_req(0, 0, 0, 0);
    tick();

    // 2 priority
    set_req(0, 1, 0, 0);
    check("prio_id", {26'h0, stall}, 32'h07);
    set_req(0, 1, 1, 0);
    check("prio_id_ex", {26'h0, stall}, 32'h0f);
    set_req(1, 0, 0, 1);
    check("prio_if_mem", {26'h0, stall}, 32'h1f);
    set_req(1, 0, 0, 0);
    check("prio_if", {26'h0, stall}, 32'h03);
    set_req(0, 0, 0, 0);
    check("prio_none", {26'h0, stall}, 32'h00);
    tick();

    // 3 exception with MEM stall pending
    exc_valid   = 1'b1;
    exc_is_eret = 1'b0;
    set_req(0, 0, 0, 1);
    check("exc_freeze", {26'h0, stall}, 32'h3f);
    tick();
    exc_valid = 1'b0;
    #1;
    check("exc_flush", {31'h0, flush}, 32'h1);
    check("exc_new_pc", new_pc, 32'h40);
    check("exc_flush_stall", {26'h0, stall}, 32'h0);
    check("exc_state", {31'h0, dbg_state}, 32'h1);
    tick();
    check("exc_flush_end", {31'h0, flush}, 32'h0);
    check("exc_after_stall", {26'h0, stall}, 32'h1f);
    set_req(0, 0, 0, 0);
    tick();

    // 4 ERET, exc_valid held through FLUSH
    cp0_epc     = 32'h0000_1234;
    exc_valid   = 1'b1;
    exc_is_eret = 1'b1;
    #1;
    check("eret_freeze", {26'h0, stall}, 32'h3f);
    tick();
    check("eret_flush", {31'h0, flush}, 32'h1);
    check("eret_new_pc", new_pc, 32'h1234);
    check("eret_ignored", {26'h0, stall}, 32'h0);
    tick();
    check("eret_n2_flush", {31'h0, flush}, 32'h0);
    check("eret_n2_freeze", {26'h0, stall}, 32'h3f);
    cp0_epc = 32'h0000_5678;
    #1;
    tick();
    check("eret_n3_flush", {31'h0, flush}, 32'h1);
    check("eret_n3_new_pc", new_pc, 32'h5678);
    exc_valid   = 1'b0;
    exc_is_eret = 1'b0;
    tick();
    check("eret_n4_flush", {31'h0, flush}, 32'h0);
    check("eret_hold_pc", new_pc, 32'h5678);
    tick();

    // 5 timeout: 7 stalled cycles then drop
    set_req(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) tick();
    check("to7_timeout", {31'h0, timeout}, 32'h0);
    set_req(0, 0, 0, 0);
    tick();
    tick();
    check("to7_after", {31'h0, timeout}, 32'h0);

    // held 8 cycles
    set_req(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) tick();
    check("to8_pre", {31'h0, timeout}, 32'h0);
    tick();
    check("to8_set", {31'h0, timeout}, 32'h1);
    check("to8_stall", {26'h0, stall}, 32'h0f);
    check("to8_flush", {31'h0, flush}, 32'h0);
    set_req(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    check("to8_sticky", {31'h0, timeout}, 32'h1);

    // 6 reset during FLUSH
    exc_valid = 1'b1;
    #1;
    tick();
    exc_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("rstmid_stall", {26'h0, stall}, 32'h0);
    tick();
    rst = 1'b0;
    set_req(0, 1, 0, 0);
    check("rstmid_flush", {31'h0, flush}, 32'h0);
    check("rstmid_state", {31'h0, dbg_state}, 32'h0);
    check("rstmid_stall_req", {26'h0, stall}, 32'h07);
    check("rstmid_new_pc", new_pc, 32'h0);
    check("rstmid_timeout", {31'h0, timeout}, 32'h0);
    set_req(0, 0, 0, 0);
    tick();

    // reset during the freeze cycle drops the redirect
    exc_valid = 1'b1;
    rst       = 1'b1;
    #1;
    check("rstfrz_stall", {26'h0, stall}, 32'h0);
    tick();
    rst       = 1'b0;
    exc_valid = 1'b0;
    #1;
    check("rstfrz_flush", {31'h0, flush}, 32'h0);
    tick();
    check("rstfrz_flush2", {31'h0, flush}, 32'h0);
    check("rstfrz_new_pc", new_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
